// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and byte-level helpers (S-box, Rcon).
// Used by aes_key_round and aes_key_schedule; optional macro AES_KEYSCHED_REVERSE_EN
// only affects aes_key_schedule.
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;

    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse (x^254, with 0 -> 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] e;
        inv = 8'h01;
        e   = 8'hfe;
        for (int i = 7; i >= 0; i--) begin
            inv = gf_mul(inv, inv);
            if (e[i]) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant top byte for rounds 1..10; zero elsewhere
    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_round.sv
// Combinational single-round AES-128 key expansion: (prev_key, round) -> next_key_c.
module aes_key_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] prev_key,
    input  logic [3:0]         round,
    output logic [BLOCK_W-1:0] next_key_c
);

    word_t w0, w1, w2, w3;
    word_t rot, t;
    word_t n0, n1, n2, n3;

    // RotWord, SubWord, Rcon, then the word XOR chain
    always_comb begin
        w0  = prev_key[127:96];
        w1  = prev_key[95:64];
        w2  = prev_key[63:32];
        w3  = prev_key[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon(round), 24'h000000};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        next_key_c = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion with an 11-entry round-key file and a
// registered indexed read port. Optional macro AES_KEYSCHED_REVERSE_EN adds
// rd_reverse, which serves rk[10 - rd_idx] for decryption order.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic [IDX_W-1:0]   rd_idx,
`ifdef AES_KEYSCHED_REVERSE_EN
    input  logic               rd_reverse,
`endif
    output logic [BLOCK_W-1:0] rd_key,
    output logic               keys_valid,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;
    localparam int unsigned NKEYS   = NR + 1;

    logic [1:0]       state, state_nxt;
    logic [3:0]       rnd, rnd_nxt;
    block_t           rk [NKEYS];
    block_t           last_key;
    block_t           round_key_c;
    logic             accept_c;
    logic             rk_we_c;
    logic [3:0]       rk_waddr_c;
    block_t           rk_wdata_c;
    logic             key_ready_nxt, keys_valid_nxt, busy_nxt, done_nxt;
    logic [IDX_W-1:0] eff_idx_c;
    block_t           rd_data_c;

    aes_key_round u_round (
        .prev_key   (last_key),
        .round      (rnd),
        .next_key_c (round_key_c)
    );

    // Next-state, round counter and register-file write selection
    always_comb begin
        state_nxt      = state;
        rnd_nxt        = rnd;
        keys_valid_nxt = keys_valid;
        done_nxt       = 1'b0;
        rk_we_c        = 1'b0;
        rk_waddr_c     = 4'd0;
        rk_wdata_c     = '0;
        accept_c       = key_valid & key_ready;
        case (state)
            S_IDLE, S_READY: begin
                if (accept_c) begin
                    state_nxt      = S_EXPAND;
                    rnd_nxt        = 4'd1;
                    keys_valid_nxt = 1'b0;
                    rk_we_c        = 1'b1;
                    rk_wdata_c     = key_in;
                end
            end
            S_EXPAND: begin
                rk_we_c    = 1'b1;
                rk_waddr_c = rnd;
                rk_wdata_c = round_key_c;
                rnd_nxt    = rnd + 4'd1;
                if (rnd == 4'(NR)) begin
                    state_nxt      = S_READY;
                    keys_valid_nxt = 1'b1;
                    done_nxt       = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        key_ready_nxt = (state_nxt != S_EXPAND);
        busy_nxt      = (state_nxt == S_EXPAND);
    end

    // Read index mapping; out-of-range indices read as zero
    always_comb begin
        eff_idx_c = rd_idx;
`ifdef AES_KEYSCHED_REVERSE_EN
        if (rd_reverse && (rd_idx <= 4'(NR))) eff_idx_c = 4'(NR) - rd_idx;
`endif
        rd_data_c = (eff_idx_c <= 4'(NR)) ? rk[eff_idx_c] : '0;
    end

    // State, counter and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rnd        <= 4'd0;
            key_ready  <= 1'b1;
            keys_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rnd        <= rnd_nxt;
            key_ready  <= key_ready_nxt;
            keys_valid <= keys_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

    // Round-key file, chaining register and read-before-write read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NKEYS; i++) rk[i] <= '0;
            last_key <= '0;
            rd_key   <= '0;
        end else begin
            if (rk_we_c) begin
                rk[rk_waddr_c] <= rk_wdata_c;
                last_key       <= rk_wdata_c;
            end
            rd_key <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: word-level FIPS-197 reference model,
// directed known-answer cases and randomized traffic.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic [3:0]   rd_idx;
    logic         rd_reverse;
    logic [127:0] rd_key;
    logic         keys_valid;
    logic         busy;
    logic         done;

    aes_key_schedule dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .rd_idx     (rd_idx),
`ifdef AES_KEYSCHED_REVERSE_EN
        .rd_reverse (rd_reverse),
`endif
        .rd_key     (rd_key),
        .keys_valid (keys_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int n_cmp = 0;
    int n_bad = 0;
    int cycle = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    logic [7:0]   sb [256];
    logic [127:0] m_rk [11];
    logic [127:0] m_key;
    logic [127:0] m_rdkey;
    logic         m_exp, m_kv, m_done;
    int           m_r;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cycle, act, want);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box built by walking GF(2^8) with generator 3 and its inverse
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Reference round key n from the 44-word FIPS-197 expansion
    function automatic logic [127:0] ref_rk(input logic [127:0] key, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 11; i++) m_rk[i] = '0;
        m_exp = 1'b0; m_kv = 1'b0; m_done = 1'b0; m_rdkey = '0; m_r = 0; m_key = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".key_ready"},  128'(key_ready),  128'(!m_exp));
        chk({tag, ".busy"},       128'(busy),       128'(m_exp));
        chk({tag, ".keys_valid"}, 128'(keys_valid), 128'(m_kv));
        chk({tag, ".done"},       128'(done),       128'(m_done));
        chk({tag, ".rd_key"},     rd_key,           m_rdkey);
    endtask

    // Advance one clock: predict from pre-edge inputs, then compare after the edge
    task automatic step();
        int idx;
        logic [127:0] want_rd;
        idx = int'(rd_idx);
`ifdef AES_KEYSCHED_REVERSE_EN
        if (rd_reverse && idx <= 10) idx = 10 - idx;
`endif
        want_rd = (idx <= 10) ? m_rk[idx] : '0;
        if (rst) begin
            model_reset();
        end else begin
            m_done = 1'b0;
            if (m_exp) begin
                m_rk[m_r] = ref_rk(m_key, m_r);
                if (m_r == 10) begin
                    m_exp = 1'b0; m_kv = 1'b1; m_done = 1'b1;
                end else begin
                    m_r++;
                end
            end else if (key_valid) begin
                m_key = key_in; m_rk[0] = key_in; m_r = 1; m_exp = 1'b1; m_kv = 1'b0;
            end
            m_rdkey = want_rd;
        end
        @(posedge clk);
        #1;
        cycle++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cycle;
        end
        check_outputs("cyc");
    endtask

    task automatic read_idx(input logic [3:0] i);
        rd_idx = i;
        step();
    endtask

    initial begin
        int acc_cyc;
        int dc_before;
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_idx = 4'd0; rd_reverse = 1'b0;
        build_sbox();
        model_reset();
        chk("sbox00", 128'(sb[8'h00]), 128'h63);
        chk("sbox01", 128'(sb[8'h01]), 128'h7c);
        chk("sbox53", 128'(sb[8'h53]), 128'hed);
        chk("model_fips_rk1", ref_rk(FIPS_KEY, 1), FIPS_RK1);
        chk("model_fips_rk10", ref_rk(FIPS_KEY, 10), FIPS_RK10);
        chk("model_zero_rk1", ref_rk('0, 1), ZERO_RK1);
        chk("model_zero_rk10", ref_rk('0, 10), ZERO_RK10);

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;
        step();

        // FIPS-197 key: done exactly once, 10 cycles after accept
        key_valid = 1'b1; key_in = FIPS_KEY;
        step();
        acc_cyc = cycle;
        key_valid = 1'b0;
        repeat (10) step();
        chk("fips_done_count", 128'(done_cnt), 128'd1);
        chk("fips_done_latency", 128'(done_cyc - acc_cyc), 128'd10);
        read_idx(4'd1);
        chk("fips_rk1", rd_key, FIPS_RK1);
        read_idx(4'd10);
        chk("fips_rk10", rd_key, FIPS_RK10);
        // Read latency: index change is not visible until the next edge
        rd_idx = 4'd1;
        #2;
        chk("rd_latency_hold", rd_key, FIPS_RK10);
        step();
        chk("rd_latency_update", rd_key, FIPS_RK1);
`ifdef AES_KEYSCHED_REVERSE_EN
        rd_reverse = 1'b1;
        read_idx(4'd0);
        chk("rev_idx0", rd_key, FIPS_RK10);
        read_idx(4'd12);
        chk("rev_oob", rd_key, 128'h0);
        rd_reverse = 1'b0;
`endif

        // Out-of-range sweep
        for (int i = 11; i < 16; i++) begin
            read_idx(4'(i));
            chk("oob_zero", rd_key, 128'h0);
        end

        // All-zero key, accepted from READY
        key_valid = 1'b1; key_in = '0;
        step();
        key_valid = 1'b0;
        repeat (10) step();
        read_idx(4'd1);
        chk("zero_rk1", rd_key, ZERO_RK1);
        read_idx(4'd10);
        chk("zero_rk10", rd_key, ZERO_RK10);

        // key_valid held through EXPAND with a different key: second key waits for READY
        key_valid = 1'b1; key_in = FIPS_KEY;
        step();
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        repeat (10) step();
        chk("held_ready", 128'(key_ready), 128'd1);
        step();
        chk("held_kv_drop", 128'(keys_valid), 128'd0);
        key_valid = 1'b0;
        repeat (10) step();
        read_idx(4'd10);
        chk("held_rk10", rd_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Reset at cycle 5 of expansion
        key_valid = 1'b1; key_in = FIPS_KEY;
        step();
        key_valid = 1'b0;
        dc_before = done_cnt;
        repeat (5) step();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            read_idx(4'(i));
            chk("post_rst_zero", rd_key, 128'h0);
        end
        chk("post_rst_no_done", 128'(done_cnt), 128'(dc_before));

        // Randomized traffic
        for (int n = 0; n < 900; n++) begin
            key_valid  = ($urandom_range(0, 3) == 0);
            key_in     = {$urandom, $urandom, $urandom, $urandom};
            rd_idx     = 4'($urandom_range(0, 15));
            rd_reverse = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
